// File: rtl/wb_master_lsu_pkg.sv
// Shared definitions for the load/store unit: Wishbone widths, size codes,
// FSM encoding and the alignment rule used at request accept.
package wb_master_lsu_pkg;

    localparam int WB_DWIDTH = 32;
    localparam int WB_AWIDTH = 32;
    localparam int WB_SWIDTH = 2;

    localparam int LSU_DEF_TIMEOUT = 15;

    localparam logic [1:0] LSU_SZ_B   = 2'b00;
    localparam logic [1:0] LSU_SZ_H   = 2'b01;
    localparam logic [1:0] LSU_SZ_W   = 2'b10;
    localparam logic [1:0] LSU_SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // The reserved size code is treated as misaligned so it never reaches the bus.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] adr_lo);
        logic bad;
        case (size)
            LSU_SZ_B: bad = 1'b0;
            LSU_SZ_H: bad = adr_lo[0];
            LSU_SZ_W: bad = |adr_lo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extender: selects byte/half/word from right-justified data and
// zero- or sign-extends it. Purely combinational, shared with the refill path.
module lsu_load_ext
    import wb_master_lsu_pkg::*;
#(
    parameter int DWIDTH = WB_DWIDTH,
    parameter int SWIDTH = WB_SWIDTH
) (
    input  logic [DWIDTH-1:0] dat,
    input  logic [SWIDTH-1:0] size,
    input  logic              sign_ext,
    output logic [DWIDTH-1:0] ext_dat
);

    always_comb begin
        ext_dat = dat;
        case (size)
            LSU_SZ_B: ext_dat = {{(DWIDTH-8){sign_ext & dat[7]}}, dat[7:0]};
            LSU_SZ_H: ext_dat = {{(DWIDTH-16){sign_ext & dat[15]}}, dat[15:0]};
            default:  ext_dat = dat;
        endcase
    end

endmodule

// File: rtl/wb_master_lsu.sv
// Core-side load/store unit: one request at a time turned into a Wishbone
// classic single transfer, with alignment and ack-timeout error reporting.
//
// state   | meaning
// IDLE    | ready for a core request
// BUS     | cyc/stb asserted, waiting for ack or timeout
// RESP    | one-cycle response pulse to the core
module wb_master_lsu
    import wb_master_lsu_pkg::*;
#(
    parameter int DWIDTH  = WB_DWIDTH,
    parameter int AWIDTH  = WB_AWIDTH,
    parameter int SWIDTH  = WB_SWIDTH,
    parameter int TIMEOUT = LSU_DEF_TIMEOUT
) (
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [SWIDTH-1:0] i_req_size,
    input  logic              i_req_signed,
    input  logic [AWIDTH-1:0] i_req_adr,
    input  logic [DWIDTH-1:0] i_req_dat,
    output logic              o_rsp_valid,
    output logic [DWIDTH-1:0] o_rsp_dat,
    output logic              o_rsp_err,
    output logic              o_wb_we,
    output logic [SWIDTH-1:0] o_wb_sel,
    output logic [AWIDTH-1:0] o_wb_adr,
    output logic [DWIDTH-1:0] o_wb_dat,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    input  logic [DWIDTH-1:0] i_wb_dat,
    input  logic              i_wb_ack
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t        state, state_d;
    logic [7:0]        wait_cnt, wait_cnt_d;
    logic              req_signed, req_signed_d;
    logic              wb_we_d;
    logic [SWIDTH-1:0] wb_sel_d;
    logic [AWIDTH-1:0] wb_adr_d;
    logic [DWIDTH-1:0] wb_dat_d;
    logic              wb_cyc_d;
    logic              rsp_valid_d;
    logic [DWIDTH-1:0] rsp_dat_d;
    logic              rsp_err_d;
    logic [DWIDTH-1:0] ext_dat;

    lsu_load_ext #(
        .DWIDTH (DWIDTH),
        .SWIDTH (SWIDTH)
    ) u_load_ext (
        .dat      (i_wb_dat),
        .size     (o_wb_sel),
        .sign_ext (req_signed),
        .ext_dat  (ext_dat)
    );

    // Ready is held low while reset is asserted so every port reads 0 in reset.
    assign o_req_ready = (state == ST_IDLE) && !i_rst;

    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        req_signed_d = req_signed;
        wb_we_d      = o_wb_we;
        wb_sel_d     = o_wb_sel;
        wb_adr_d     = o_wb_adr;
        wb_dat_d     = o_wb_dat;
        wb_cyc_d     = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_dat_d    = o_rsp_dat;
        rsp_err_d    = o_rsp_err;

        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (lsu_misaligned(i_req_size, i_req_adr[1:0])) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_dat_d   = '0;
                        state_d     = ST_RESP;
                    end else begin
                        req_signed_d = i_req_signed;
                        wb_we_d      = i_req_we;
                        wb_sel_d     = i_req_size;
                        wb_adr_d     = i_req_adr;
                        wb_dat_d     = i_req_dat;
                        wb_cyc_d     = 1'b1;
                        wait_cnt_d   = '0;
                        state_d      = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                wb_cyc_d   = 1'b1;
                wait_cnt_d = wait_cnt + 8'd1;
                // Ack is checked first so a last-cycle ack is not reported as a timeout.
                if (i_wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = o_wb_we ? '0 : ext_dat;
                    state_d     = ST_RESP;
                end else if (wait_cnt == TO_LAST) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_ck or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            req_signed  <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_sel    <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            req_signed  <= req_signed_d;
            o_wb_we     <= wb_we_d;
            o_wb_sel    <= wb_sel_d;
            o_wb_adr    <= wb_adr_d;
            o_wb_dat    <= wb_dat_d;
            o_wb_cyc    <= wb_cyc_d;
            o_wb_stb    <= wb_cyc_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_dat   <= rsp_dat_d;
            o_rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_master_lsu.sv
// Self-checking bench for wb_master_lsu: behavioural Wishbone slave with
// programmable ack latency and a response scoreboard.
module tb_wb_master_lsu;

    logic        i_ck = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'b00;
    logic        i_req_signed = 1'b0;
    logic [31:0] i_req_adr = '0;
    logic [31:0] i_req_dat = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_dat;
    logic        o_rsp_err;
    logic        o_wb_we;
    logic [1:0]  o_wb_sel;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_ack = 1'b0;

    wb_master_lsu #(
        .DWIDTH (32), .AWIDTH (32), .SWIDTH (2), .TIMEOUT (15)
    ) dut (
        .i_ck         (i_ck),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_size   (i_req_size),
        .i_req_signed (i_req_signed),
        .i_req_adr    (i_req_adr),
        .i_req_dat    (i_req_dat),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_dat    (o_rsp_dat),
        .o_rsp_err    (o_rsp_err),
        .o_wb_we      (o_wb_we),
        .o_wb_sel     (o_wb_sel),
        .o_wb_adr     (o_wb_adr),
        .o_wb_dat     (o_wb_dat),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .i_wb_dat     (i_wb_dat),
        .i_wb_ack     (i_wb_ack)
    );

    always #5 i_ck = ~i_ck;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   rsp_count = 0;

    // Slave model: acks on the ack_lat-th stb cycle (0 = never); ack_force injects stray acks.
    int          ack_lat = 2;
    logic        ack_force = 1'b0;
    logic        slave_adr_mode = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          stb_seen = 0;

    always @(negedge i_ck) begin
        if (o_wb_cyc && o_wb_stb) stb_seen = stb_seen + 1;
        else                      stb_seen = 0;
        i_wb_ack = ack_force || (ack_lat != 0 && stb_seen == ack_lat);
        i_wb_dat = slave_adr_mode ? {o_wb_adr[15:0], 16'hC0DE} : slave_rdata;
    end

    always @(negedge i_ck) begin : scoreboard
        exp_t e;
        if (o_rsp_valid) begin
            rsp_count = rsp_count + 1;
            n_tests = n_tests + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rsp_unexpected: got dat=%h err=%b, required no response", o_rsp_dat, o_rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (o_rsp_dat !== e.dat || o_rsp_err !== e.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_data: got dat=%h err=%b, required dat=%h err=%b",
                             o_rsp_dat, o_rsp_err, e.dat, e.err);
                end
            end
        end
    end

    // Presents a request and returns 1ns after the clock edge that accepted it.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] adr, input logic [31:0] dat, input bit hold);
        bit got;
        got = 1'b0;
        @(negedge i_ck);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_size   = size;
        i_req_signed = sgn;
        i_req_adr    = adr;
        i_req_dat    = dat;
        for (int k = 0; k < 50; k++) begin
            if (o_req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge i_ck);
        end
        if (!got) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL req_accept: got ready=0 for 50 cycles, required ready=1");
        end
        @(posedge i_ck);
        #1;
        if (!hold) i_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_ck);
            if (o_rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err, o_req_ready} !== 6'b0 ||
            o_wb_adr !== 32'h0 || o_wb_dat !== 32'h0 || o_rsp_dat !== 32'h0 || o_wb_sel !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cyc=%b stb=%b rdy=%b rsp=%b adr=%h, required all 0",
                     o_wb_cyc, o_wb_stb, o_req_ready, o_rsp_valid, o_wb_adr);
        end
        repeat (3) @(negedge i_ck);
        i_rst = 1'b0;
        #1;
        n_tests++;
        if (o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1", o_req_ready);
        end
    endtask

    task automatic test_word_store();
        int  cyc_cnt, rsp_k;
        bit  bus_ok;
        ack_lat = 2;
        slave_adr_mode = 1'b0;
        exp_q.push_back('{32'h0, 1'b0});
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        cyc_cnt = 0; rsp_k = -1; bus_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_ck);
            if (o_wb_cyc) begin
                cyc_cnt++;
                if (!(o_wb_stb && o_wb_we && o_wb_sel == 2'b10 && o_wb_adr == 32'h10 &&
                      o_wb_dat == 32'hDEAD_BEEF)) bus_ok = 1'b0;
            end
            if (o_rsp_valid && rsp_k < 0) rsp_k = k;
        end
        n_tests++;
        if (cyc_cnt != 2) begin
            n_fail++; $display("FAIL store_cyc_len: got %0d, required 2", cyc_cnt);
        end
        n_tests++;
        if (!bus_ok) begin
            n_fail++; $display("FAIL store_bus_fields: got unstable/incorrect we/sel/adr/dat, required we=1 sel=2 adr=10 dat=deadbeef");
        end
        n_tests++;
        if (rsp_k != 3) begin
            n_fail++; $display("FAIL store_rsp_cycle: got %0d, required 3", rsp_k);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  t_sz [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        logic        t_sg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_adr[6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h20, 32'h21};
        logic [31:0] t_rd [6] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'h0000_8001,
                                  32'h8765_4321, 32'h0000_007F};
        logic [31:0] t_ex [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                  32'h8765_4321, 32'h0000_007F};
        int lat;
        ack_lat = 2;
        slave_adr_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slave_rdata = t_rd[i];
            exp_q.push_back('{t_ex[i], 1'b0});
            do_req(1'b0, t_sz[i], t_sg[i], t_adr[i], 32'hFFFF_FFFF, 1'b0);
            wait_rsp(lat);
            n_tests++;
            if (lat != 3) begin
                n_fail++; $display("FAIL load_latency[%0d]: got %0d, required 3", i, lat);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  t_sz [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] t_adr[4] = '{32'h1, 32'h2, 32'h1, 32'h0};
        bit saw_cyc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{32'h0, 1'b1});
            do_req(1'b0, t_sz[i], 1'b1, t_adr[i], 32'h0, 1'b0);
            saw_cyc = 1'b0;
            @(negedge i_ck);
            if (o_wb_cyc) saw_cyc = 1'b1;
            n_tests++;
            if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1) begin
                n_fail++;
                $display("FAIL misalign_rsp[%0d]: got valid=%b err=%b, required valid=1 err=1",
                         i, o_rsp_valid, o_rsp_err);
            end
            repeat (3) begin
                @(negedge i_ck);
                if (o_wb_cyc) saw_cyc = 1'b1;
            end
            n_tests++;
            if (saw_cyc) begin
                n_fail++; $display("FAIL misalign_nobus[%0d]: got cyc=1, required cyc=0", i);
            end
        end
    endtask

    task automatic test_timeout();
        int stb_cnt, rsp_k, lat;
        bit late_bad;
        ack_lat = 0;
        exp_q.push_back('{32'h0, 1'b1});
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        stb_cnt = 0; rsp_k = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge i_ck);
            if (o_wb_stb) stb_cnt++;
            if (o_rsp_valid && rsp_k < 0) rsp_k = k;
        end
        n_tests++;
        if (stb_cnt != 15) begin
            n_fail++; $display("FAIL timeout_stb_len: got %0d, required 15", stb_cnt);
        end
        n_tests++;
        if (rsp_k != 16) begin
            n_fail++; $display("FAIL timeout_rsp_cycle: got %0d, required 16", rsp_k);
        end
        ack_force = 1'b1;
        late_bad = 1'b0;
        repeat (4) begin
            @(negedge i_ck);
            if (o_wb_cyc || o_rsp_valid) late_bad = 1'b1;
        end
        ack_force = 1'b0;
        @(negedge i_ck);
        n_tests++;
        if (late_bad || o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack_ignored: got activity=%b ready=%b, required activity=0 ready=1",
                     late_bad, o_req_ready);
        end
        // Ack on the final allowed cycle must complete without error.
        ack_lat = 15;
        slave_rdata = 32'h5A5A_5A5A;
        exp_q.push_back('{32'h5A5A_5A5A, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0);
        wait_rsp(lat);
        n_tests++;
        if (lat != 16) begin
            n_fail++; $display("FAIL ack_at_timeout: got latency %0d, required 16", lat);
        end
    endtask

    task automatic test_reset_mid();
        int pre, lat;
        ack_lat = 0;
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
        repeat (2) @(negedge i_ck);
        n_tests++;
        if (o_wb_stb !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre_stb: got %b, required 1", o_wb_stb);
        end
        pre = rsp_count;
        #2 i_rst = 1'b1;
        #1;
        n_tests++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got cyc=%b stb=%b rdy=%b, required 0 0 0",
                     o_wb_cyc, o_wb_stb, o_req_ready);
        end
        @(negedge i_ck);
        i_rst = 1'b0;
        repeat (20) @(negedge i_ck);
        n_tests++;
        if (rsp_count != pre) begin
            n_fail++; $display("FAIL rst_mid_no_rsp: got %0d responses, required 0", rsp_count - pre);
        end
        ack_lat = 2;
        slave_rdata = 32'h1234_5678;
        exp_q.push_back('{32'h1234_5678, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 1'b0);
        wait_rsp(lat);
        n_tests++;
        if (lat != 3) begin
            n_fail++; $display("FAIL rst_mid_next_load: got latency %0d, required 3", lat);
        end
    endtask

    task automatic test_back_to_back();
        bit rdy_ok, adr_ok;
        int rsp_mask;
        ack_lat = 2;
        slave_adr_mode = 1'b1;
        exp_q.push_back('{32'h0100_C0DE, 1'b0});
        exp_q.push_back('{32'hFFFF_C0DE, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        i_req_size   = 2'b01;
        i_req_signed = 1'b1;
        i_req_adr    = 32'h206;
        rdy_ok = 1'b1; adr_ok = 1'b1; rsp_mask = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_ck);
            if (o_req_ready !== (k == 4 || k == 8)) rdy_ok = 1'b0;
            if ((k == 1 || k == 2) && (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h100)) adr_ok = 1'b0;
            if ((k == 5 || k == 6) && (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h206)) adr_ok = 1'b0;
            if (o_rsp_valid) rsp_mask = rsp_mask | (1 << k);
            if (k == 5) i_req_valid = 1'b0;
        end
        n_tests++;
        if (!rdy_ok) begin
            n_fail++; $display("FAIL b2b_ready: got ready outside IDLE slots, required ready only at cycles 4 and 8");
        end
        n_tests++;
        if (!adr_ok) begin
            n_fail++; $display("FAIL b2b_bus_order: got wrong bus address sequence, required 100 then 206");
        end
        n_tests++;
        if (rsp_mask != ((1 << 3) | (1 << 7))) begin
            n_fail++; $display("FAIL b2b_rsp_spacing: got mask %h, required %h", rsp_mask, (1 << 3) | (1 << 7));
        end
        slave_adr_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge i_ck);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_lsu.md
Name: wb_master_lsu

Overview:
- Load/store unit on the core data side. It converts one core memory request at a time into a Wishbone classic single-transfer cycle toward the data-memory Wishbone slave.
- It sits directly upstream of that slave. It drives cyc/stb/we/sel/adr/dat, waits for a variable-latency ack, then returns extended read data or a store completion to the core.
- Alignment and timeout errors are reported to the core. No bus transaction is ever issued for a misaligned request.

Parameters:
- DWIDTH, 32, Wishbone data width; equals `WB_DWIDTH.
- AWIDTH, 32, Wishbone address width; equals `WB_AWIDTH.
- SWIDTH, 2, access-size code width; equals `WB_SWIDTH.
- TIMEOUT, 15, maximum stb cycles without ack before error; range 1..255.

Ports:
- i_ck  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_req_valid  in  1  core request present
- o_req_ready  out  1  LSU accepts request this cycle
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  SWIDTH  access size: 00 byte, 01 half, 10 word, 11 reserved
- i_req_signed  in  1  load sign-extends when 1
- i_req_adr  in  AWIDTH  byte address
- i_req_dat  in  DWIDTH  store data, right-justified
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_dat  out  DWIDTH  extended load data; 0 for stores and errors
- o_rsp_err  out  1  error qualifier, valid with o_rsp_valid
- o_wb_we  out  1  Wishbone write enable
- o_wb_sel  out  SWIDTH  size code to slave
- o_wb_adr  out  AWIDTH  Wishbone address
- o_wb_dat  out  DWIDTH  Wishbone write data
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- i_wb_dat  in  DWIDTH  Wishbone read data, right-justified
- i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- All outputs are registered except o_req_ready, which is decoded from state.
- Reset values: every output is 0, and state is IDLE. o_req_ready becomes 1 once reset is released.
- FSM states are IDLE, BUS and RESP.

IDLE:
- o_req_ready = 1.
- On i_req_valid, the request fields are registered.
- Misaligned request: half with adr[0]=1, word with adr[1:0]≠0, or size 11. Go to RESP with err=1 and no bus activity.
- Aligned request: go to BUS. cyc/stb/we/sel/adr/dat are driven from registers starting the next cycle.

BUS:
- o_req_ready = 0.
- cyc = stb = 1. we/sel/adr/dat are held stable.
- A wait counter (8 bits) clears on BUS entry and increments each BUS cycle.
- When i_wb_ack = 1:
  - Load: capture i_wb_dat through the load extender.
  - Store: response data is 0.
  - cyc/stb drop at the same edge; go to RESP with err=0.
- When the counter reaches TIMEOUT-1 without ack: drop cyc/stb, go to RESP with err=1, data 0.
- Ack and timeout in the same cycle: ack wins.

RESP:
- o_rsp_valid = 1 for exactly one cycle; then return to IDLE.
- The core must accept the response unconditionally.

Load extension:
- Byte: bits [7:0]. Half: bits [15:0]. Word: passes through unchanged.
- Upper bits are filled with the MSB of the field when signed=1, else with 0.

Timing and other rules:
- Against a slave that acks on its 2nd stb cycle, an access takes 4 cycles from accept to response: accept, stb, stb+ack, rsp.
- i_wb_ack outside BUS is ignored.
- Reset mid-operation: cyc/stb clear immediately without a clock edge. The pending request is discarded and no response is issued.
- Stores are issued with o_wb_we=1. Nothing in this block gates the write on stb; the slave does that.

Decomposition:
- Shared header lsu_defs.vh holds size codes (LSU_SZ_B/H/W), FSM state encodings and the default TIMEOUT. The Wishbone widths come from config.vh.
- One combinational sub-module is natural: lsu_load_ext. Inputs are data, size and signed; output is the extended word. It is reused later by a cache refill path.

Test Plan:
1. Word store, adr 0x0000_0010, dat 0xDEADBEEF, slave acks on 2nd stb cycle:
   - cyc/stb are high exactly 2 cycles, with we=1 and sel=10.
   - rsp_valid pulses at cycle 3 with err=0 and dat=0.
2. Byte load at adr 0x0000_0013, slave returns 0x0000_0080:
   - signed → rsp_dat 0xFFFFFF80.
   - unsigned → 0x00000080.
   - Signed half with 0x0000_8001 → 0xFFFF8001.
3. Half load at adr 0x0000_0001:
   - cyc never asserts.
   - rsp_valid and err=1 arrive the cycle after accept, with dat=0.
4. Slave never acks, TIMEOUT=15:
   - stb is high exactly 15 cycles, then cyc/stb=0.
   - Response has err=1 and returns to IDLE.
   - A late ack after the drop is ignored.
5. i_rst pulses while stb=1:
   - cyc/stb go to 0 asynchronously, with no rsp_valid after release.
   - The next word load completes normally with err=0.
6. i_req_valid held high for two loads:
   - ready is high only in IDLE, and responses arrive in order.
   - Spacing is 4 cycles with a 2-cycle-ack slave; the second request is not accepted during BUS/RESP.
